prbs10_checker: RTL and testbench

//  Serial receiver/checker for the 10-bit x^10+x^7+1 LFSR stream that drives game LED selection.

---
 rtl/prbs10_checker_if.sv | 23 ++
 rtl/prbs10_checker.sv | 125 ++++++++++++
 tb/tb_prbs10_checker.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/prbs10_checker_if.sv
// Bit-stream handshake and checker status bundle for prbs10_checker.
// The master drives the received bit and clear request; the slave reports lock and error status.
interface prbs10_checker_if #(
  parameter int unsigned ERRCNT_W = 16
);
  logic                bit_valid;
  logic                bit_in;
  logic                clear_count;
  logic                locked;
  logic                bit_error;
  logic                lock_lost;
  logic [ERRCNT_W-1:0] error_count;

  modport master (
    output bit_valid, bit_in, clear_count,
    input  locked, bit_error, lock_lost, error_count
  );

  modport slave (
    input  bit_valid, bit_in, clear_count,
    output locked, bit_error, lock_lost, error_count
  );
endinterface

// File: rtl/prbs10_checker.sv
// Self-synchronising checker for the x^10+x^7+1 LFSR bit stream.
// It locks after a run of correct predictions, then flywheels and counts bit errors per window.
module prbs10_checker #(
  parameter int unsigned LOCK_COUNT = 16,
  parameter int unsigned WINDOW     = 64,
  parameter int unsigned ERR_LIMIT  = 4,
  parameter int unsigned ERRCNT_W   = 16
) (
  input  logic             clk_i,
  input  logic             reset_i,
  prbs10_checker_if.slave  bus
);

  localparam logic [0:0]  ST_SEARCH = 1'b0;
  localparam logic [0:0]  ST_LOCKED = 1'b1;
  localparam logic [3:0]  FILL_LEN  = 4'd10;
  localparam logic [7:0]  RUN_LAST  = 8'(LOCK_COUNT - 1);
  localparam logic [15:0] WIN_LAST  = 16'(WINDOW - 1);
  localparam logic [15:0] ERR_LIM   = 16'(ERR_LIMIT);

  logic [0:0]          state_q, state_d;
  logic [10:1]         sr_q, sr_d;
  logic [3:0]          fill_q, fill_d;
  logic [7:0]          run_q, run_d;
  logic [15:0]         win_cnt_q, win_cnt_d;
  logic [15:0]         win_err_q, win_err_d;
  logic [ERRCNT_W-1:0] err_cnt_q, err_cnt_d;
  logic                bit_error_q, bit_error_d;
  logic                lock_lost_q, lock_lost_d;

  logic        pred;
  logic        mism;
  logic [15:0] win_err_n;

  assign pred      = sr_q[10] ^ sr_q[7];
  assign mism      = bus.bit_in ^ pred;
  assign win_err_n = win_err_q + {15'd0, mism};

  always_comb begin
    state_d     = state_q;
    sr_d        = sr_q;
    fill_d      = fill_q;
    run_d       = run_q;
    win_cnt_d   = win_cnt_q;
    win_err_d   = win_err_q;
    err_cnt_d   = err_cnt_q;
    bit_error_d = 1'b0;
    lock_lost_d = 1'b0;

    if (bus.bit_valid) begin
      if (state_q == ST_SEARCH) begin
        sr_d = {sr_q[9:1], bus.bit_in};
        if (fill_q != FILL_LEN) begin
          fill_d = fill_q + 4'd1;
        end else if (!mism && (sr_q != '0)) begin
          // an all-zero register predicts zero forever, so it never earns run credit
          if (run_q == RUN_LAST) begin
            state_d   = ST_LOCKED;
            run_d     = '0;
            win_cnt_d = '0;
            win_err_d = '0;
          end else begin
            run_d = run_q + 8'd1;
          end
        end else begin
          run_d = '0;
        end
      end else begin
        // flywheel: feed back our own prediction so a corrupted bit never enters sr
        sr_d = {sr_q[9:1], pred};
        if (mism) begin
          bit_error_d = 1'b1;
          if (err_cnt_q != '1) err_cnt_d = err_cnt_q + ERRCNT_W'(1);
        end
        if (win_err_n == ERR_LIM) begin
          state_d     = ST_SEARCH;
          lock_lost_d = 1'b1;
          sr_d        = '0;
          fill_d      = '0;
          run_d       = '0;
          win_cnt_d   = '0;
          win_err_d   = '0;
        end else if (win_cnt_q == WIN_LAST) begin
          win_cnt_d = '0;
          win_err_d = '0;
        end else begin
          win_cnt_d = win_cnt_q + 16'd1;
          win_err_d = win_err_n;
        end
      end
    end

    if (bus.clear_count) err_cnt_d = '0;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= ST_SEARCH;
      sr_q        <= '0;
      fill_q      <= '0;
      run_q       <= '0;
      win_cnt_q   <= '0;
      win_err_q   <= '0;
      err_cnt_q   <= '0;
      bit_error_q <= 1'b0;
      lock_lost_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      fill_q      <= fill_d;
      run_q       <= run_d;
      win_cnt_q   <= win_cnt_d;
      win_err_q   <= win_err_d;
      err_cnt_q   <= err_cnt_d;
      bit_error_q <= bit_error_d;
      lock_lost_q <= lock_lost_d;
    end
  end

  assign bus.locked      = (state_q == ST_LOCKED);
  assign bus.bit_error   = bit_error_q;
  assign bus.lock_lost   = lock_lost_q;
  assign bus.error_count = err_cnt_q;

endmodule

// File: tb/tb_prbs10_checker.sv
// Directed bench for prbs10_checker: a transmit LFSR plus a behavioural lock/error model
// feed a queue of expected outputs that is popped and compared after every clock.
module tb_prbs10_checker;

  localparam int unsigned EW        = 3;
  localparam int unsigned LOCK_CNT  = 16;
  localparam int unsigned WIN       = 64;
  localparam int unsigned ERR_LIM   = 4;
  localparam int unsigned LOCK_BITS = 10 + LOCK_CNT;

  typedef struct packed {
    logic          locked;
    logic          bit_error;
    logic          lock_lost;
    logic [EW-1:0] ecnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  prbs10_checker_if #(.ERRCNT_W(EW)) bus ();

  prbs10_checker #(
    .LOCK_COUNT(LOCK_CNT), .WINDOW(WIN), .ERR_LIMIT(ERR_LIM), .ERRCNT_W(EW)
  ) dut (
    .clk_i   (clk),
    .reset_i (rst),
    .bus     (bus)
  );

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_steps  = 0;

  // transmit generator
  logic [10:1] tx;

  // behavioural receiver model
  logic          m_locked, m_berr, m_lost;
  logic [EW-1:0] m_ecnt;
  int            m_srch, m_wcnt, m_werr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
  endtask

  task automatic sample_and_compare();
    exp_t e, got;
    @(posedge clk);
    #1;
    e   = sb_q.pop_front();
    got = {bus.locked, bus.bit_error, bus.lock_lost, bus.error_count};
    n_checks++;
    assert (got === e) n_pass++;
    else $error("FAIL step%0d: observed lk=%b be=%b ll=%b ec=%0d expected lk=%b be=%b ll=%b ec=%0d",
                n_steps, got.locked, got.bit_error, got.lock_lost, got.ecnt,
                e.locked, e.bit_error, e.lock_lost, e.ecnt);
    n_steps++;
  endtask

  task automatic do_reset(input logic v);
    rst             = 1'b1;
    bus.bit_valid   = v;
    bus.bit_in      = 1'b1;
    bus.clear_count = 1'b0;
    tx       = 10'd1;
    m_locked = 1'b0; m_berr = 1'b0; m_lost = 1'b0; m_ecnt = '0;
    m_srch   = 0;    m_wcnt = 0;    m_werr = 0;
    sb_q.push_back('{locked: 1'b0, bit_error: 1'b0, lock_lost: 1'b0, ecnt: '0});
    sample_and_compare();
    rst = 1'b0;
  endtask

  // zero=1 sends a constant-0 line instead of the LFSR stream
  task automatic step(input logic v, input logic flip, input logic clr, input logic zero);
    logic b;
    b = 1'b0;
    if (v) begin
      if (!zero) begin
        b  = tx[10] ^ tx[7];
        tx = {tx[9:1], b};
      end
      b = b ^ flip;
    end else begin
      b = 1'($urandom_range(0, 1));
    end
    bus.bit_valid   = v;
    bus.bit_in      = b;
    bus.clear_count = clr;

    m_berr = 1'b0;
    m_lost = 1'b0;
    if (v) begin
      if (!m_locked) begin
        if (!zero) begin
          m_srch++;
          if (m_srch == LOCK_BITS) begin
            m_locked = 1'b1; m_wcnt = 0; m_werr = 0;
          end
        end
      end else begin
        if (flip) begin
          m_berr = 1'b1;
          m_werr++;
          if (m_ecnt != '1) m_ecnt = m_ecnt + 1'b1;
        end
        m_wcnt++;
        if (m_werr == ERR_LIM) begin
          m_locked = 1'b0; m_lost = 1'b1; m_srch = 0; m_wcnt = 0; m_werr = 0;
        end else if (m_wcnt == WIN) begin
          m_wcnt = 0; m_werr = 0;
        end
      end
    end
    if (clr) m_ecnt = '0;
    sb_q.push_back('{locked: m_locked, bit_error: m_berr, lock_lost: m_lost, ecnt: m_ecnt});
    sample_and_compare();
  endtask

  task automatic clean(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    int vcnt;
    bus.bit_valid   = 1'b0;
    bus.bit_in      = 1'b0;
    bus.clear_count = 1'b0;

    // 1: acquisition from reset
    do_reset(1'b0);
    chk("reset_locked", 32'(bus.locked), 32'd0);
    chk("reset_errcnt", 32'(bus.error_count), 32'd0);
    clean(LOCK_BITS - 1);
    chk("t1_not_locked_25", 32'(bus.locked), 32'd0);
    clean(1);
    chk("t1_locked_26", 32'(bus.locked), 32'd1);
    clean(14);
    chk("t1_errcnt", 32'(bus.error_count), 32'd0);

    // 2: isolated error rides through
    step(1'b1, 1'b1, 1'b0, 1'b0);
    chk("t2_bit_error", 32'(bus.bit_error), 32'd1);
    chk("t2_errcnt", 32'(bus.error_count), 32'd1);
    clean(50);
    chk("t2_still_locked", 32'(bus.locked), 32'd1);
    chk("t2_errcnt_after", 32'(bus.error_count), 32'd1);

    // 3: four errors in one window, the last on the closing bit of that window
    do_reset(1'b0);
    clean(LOCK_BITS);
    for (int i = 0; i < WIN; i++)
      step(1'b1, (i == 2 || i == 4 || i == 6 || i == WIN - 1), 1'b0, 1'b0);
    chk("t3_lock_lost", 32'(bus.lock_lost), 32'd1);
    chk("t3_bit_error", 32'(bus.bit_error), 32'd1);
    chk("t3_unlocked", 32'(bus.locked), 32'd0);
    chk("t3_errcnt", 32'(bus.error_count), 32'd4);
    clean(LOCK_BITS - 1);
    chk("t3_relock_25", 32'(bus.locked), 32'd0);
    clean(1);
    chk("t3_relock_26", 32'(bus.locked), 32'd1);

    // 4: three errors in each of two windows, then a third window to saturate
    do_reset(1'b0);
    clean(LOCK_BITS);
    for (int i = 0; i < 3 * WIN; i++)
      step(1'b1, (i == 10 || i == 20 || i == 30 || i == 70 || i == 80 || i == 90),
           1'b0, 1'b0);
    chk("t4_locked", 32'(bus.locked), 32'd1);
    chk("t4_errcnt", 32'(bus.error_count), 32'd6);
    for (int i = 0; i < 40; i++)
      step(1'b1, (i == 5 || i == 15 || i == 25), 1'b0, 1'b0);
    chk("t4_saturated", 32'(bus.error_count), 32'd7);
    chk("t4_sat_locked", 32'(bus.locked), 32'd1);

    // 5a: constant-zero line never locks
    do_reset(1'b0);
    for (int i = 0; i < 200; i++) step(1'b1, 1'b0, 1'b0, 1'b1);
    chk("t5_zero_unlocked", 32'(bus.locked), 32'd0);

    // 5b: gaps in bit_valid do not advance acquisition
    do_reset(1'b0);
    vcnt = 0;
    while (vcnt < LOCK_BITS - 1) begin
      if ($urandom_range(0, 2) == 0) begin
        step(1'b0, 1'b0, 1'b0, 1'b0);
      end else begin
        step(1'b1, 1'b0, 1'b0, 1'b0);
        vcnt++;
      end
    end
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("t5_gap_unlocked", 32'(bus.locked), 32'd0);
    clean(1);
    chk("t5_gap_locked", 32'(bus.locked), 32'd1);

    // 6: reset while locked, then clear racing an error
    clean(3);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    do_reset(1'b1);
    chk("t6_reset_unlocked", 32'(bus.locked), 32'd0);
    chk("t6_reset_errcnt", 32'(bus.error_count), 32'd0);
    clean(LOCK_BITS + 4);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    chk("t6_errcnt_1", 32'(bus.error_count), 32'd1);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    chk("t6_clear_wins", 32'(bus.error_count), 32'd0);
    chk("t6_clear_pulse", 32'(bus.bit_error), 32'd1);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("t6_idle_no_pulse", 32'(bus.bit_error), 32'd0);

    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
